rf_arbiter2: RTL and testbench

Two-requester arbiter and access sequencer for the shared 16x8 register file. It lets the digit-scan HLSM and a second client share the file's single read port and single write port, for example a loader that fills it or a display walker that reads it back. Arbitration is round-robin with a bounded hold, which keeps either client from starving the other. The arbiter also steers address, enable and write data to the file and returns registered read data to whichever requester was granted.

---
 rtl/rf_arbiter2.sv | 185 ++++++++++++++++++
 tb/tb_rf_arbiter2.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_arbiter2.sv
// rf_arbiter2
// Two-requester arbiter and access sequencer for the shared 16x8 register
// file. Requester 0 (the digit-scan HLSM) and requester 1 (a loader or
// display walker) share the file's single read port and single write port.
// Grants rotate round-robin, and a bounded hold lets neither side starve the
// other. The granted requester's address, enable and write data are steered
// to the file. Read data is registered and returned to the requester that
// issued the read.
//
// Ports
//   Clk, Rst            clock; synchronous active-high reset
//   reqN                access request from requester N (N = 0, 1)
//   weN                 1 = write, 0 = read (meaningful while reqN = 1)
//   addrN, wdataN       entry address and write data of requester N
//   gntN                registered grant, one-hot or both 0
//   rvalidN             one-cycle pulse: rdataN carries fresh read data
//   rdataN              registered read data, held until N's next read
//   rf_raddr, rf_waddr  register-file read / write address
//   rf_ren, rf_wen      register-file read / write enable
//   rf_wdata            register-file write data
//   rf_rdata            register-file read data (combinational on rf_ren)

module rf_arbiter2 #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rf_raddr,
    output logic [AW-1:0] rf_waddr,
    output logic          rf_ren,
    output logic          rf_wen,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Value of the hold counter during the last access a requester may make
    // before the grant is handed to a waiting peer.
    localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [4:0]    hold_q, hold_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          acc0;
    logic          acc1;
    logic          access;

    // An access happens whenever the owner is requesting. Rst suppresses it
    // in the same cycle so that neither a write nor a read return can leak
    // out of a reset cycle.
    always_comb begin : access_decode
        acc0   = (state_q == OWN0) && req0 && !Rst;
        acc1   = (state_q == OWN1) && req1 && !Rst;
        access = acc0 || acc1;

        rf_raddr = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        rf_ren   = 1'b0;
        rf_wen   = 1'b0;
        if (acc0) begin
            rf_raddr = addr0;
            rf_waddr = addr0;
            rf_wdata = wdata0;
            rf_wen   = we0;
            rf_ren   = !we0;
        end else if (acc1) begin
            rf_raddr = addr1;
            rf_waddr = addr1;
            rf_wdata = wdata1;
            rf_wen   = we1;
            rf_ren   = !we1;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // On a tie, the requester that did not own the file last wins.
                if (req0 && req1) begin
                    state_d = last_q ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && (hold_q == HOLD_LAST)) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && (hold_q == HOLD_LAST)) begin
                    state_d = OWN0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : bookkeeping
        // The hold count belongs to the current grant only. It restarts on
        // any hand-over and in IDLE, and saturates so that a lone owner can
        // keep the file indefinitely.
        hold_d = hold_q;
        if ((state_d != state_q) || (state_q == IDLE)) begin
            hold_d = '0;
        end else if (access && (hold_q != HOLD_LAST)) begin
            hold_d = hold_q + 5'd1;
        end

        last_d = last_q;
        case (state_d)
            OWN0:    last_d = 1'b0;
            OWN1:    last_d = 1'b1;
            default: last_d = last_q;
        endcase

        rvalid0_d = acc0 && !we0;
        rvalid1_d = acc1 && !we1;
        rdata0_d  = rvalid0_d ? rf_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? rf_rdata : rdata1_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // The state register is the grant.
    assign gnt0    = (state_q == OWN0);
    assign gnt1    = (state_q == OWN1);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_rf_arbiter2.sv
// Testbench for rf_arbiter2: a register-file stub, a behavioural model of
// ownership/streak/last-winner with its own copy of the file contents,
// directed scenarios with literal expectations, and a randomized phase.

module tb_rf_arbiter2;

    localparam int AW       = 4;
    localparam int DW       = 8;
    localparam int MAX_HOLD = 16;

    logic          Clk;
    logic          rst;
    logic          req_v   [2];
    logic          we_v    [2];
    logic [AW-1:0] addr_v  [2];
    logic [DW-1:0] wdata_v [2];

    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] rf_raddr, rf_waddr;
    logic          rf_ren, rf_wen;
    logic [DW-1:0] rf_wdata, rf_rdata;

    rf_arbiter2 #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .Clk      (Clk),
        .Rst      (rst),
        .req0     (req_v[0]),
        .req1     (req_v[1]),
        .we0      (we_v[0]),
        .we1      (we_v[1]),
        .addr0    (addr_v[0]),
        .addr1    (addr_v[1]),
        .wdata0   (wdata_v[0]),
        .wdata1   (wdata_v[1]),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .rf_raddr (rf_raddr),
        .rf_waddr (rf_waddr),
        .rf_ren   (rf_ren),
        .rf_wen   (rf_wen),
        .rf_wdata (rf_wdata),
        .rf_rdata (rf_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Register-file stub. poke loads contents from the bench.
    logic [DW-1:0] mem [16];
    logic          poke_en;
    logic [AW-1:0] poke_a;
    logic [DW-1:0] poke_d;

    always @(posedge Clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (rf_wen) mem[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata = rf_ren ? mem[rf_raddr] : 8'h00;

    // Behavioural model
    int            m_owner;      // -1 none, else requester index
    int            m_streak;     // accesses made under the current grant
    int            m_last;       // most recently granted requester
    logic          m_rvalid [2];
    logic [DW-1:0] m_rdata  [2];
    logic [DW-1:0] ref_mem  [16];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nxt;
        int oth;
        m_rvalid[0] = 1'b0;
        m_rvalid[1] = 1'b0;
        if (rst) begin
            m_owner    = -1;
            m_streak   = 0;
            m_last     = 1;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            return;
        end
        if (m_owner >= 0 && req_v[m_owner]) begin
            if (we_v[m_owner]) begin
                ref_mem[addr_v[m_owner]] = wdata_v[m_owner];
            end else begin
                m_rdata[m_owner]  = ref_mem[addr_v[m_owner]];
                m_rvalid[m_owner] = 1'b1;
            end
            m_streak++;
        end
        if (m_owner < 0) begin
            if (req_v[0] && req_v[1]) nxt = 1 - m_last;
            else if (req_v[0])        nxt = 0;
            else if (req_v[1])        nxt = 1;
            else                      nxt = -1;
        end else begin
            oth = 1 - m_owner;
            if (!req_v[m_owner])                          nxt = req_v[oth] ? oth : -1;
            else if (m_streak >= MAX_HOLD && req_v[oth])  nxt = oth;
            else                                          nxt = m_owner;
        end
        if (nxt != m_owner) m_streak = 0;
        if (nxt >= 0) m_last = nxt;
        m_owner = nxt;
    endtask

    task automatic compare_model();
        logic          acc;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_wen, e_ren;
        acc = 1'b0;
        if (m_owner >= 0 && !rst) acc = req_v[m_owner];
        e_addr = '0; e_wdata = '0; e_wen = 1'b0; e_ren = 1'b0;
        if (acc) begin
            e_addr  = addr_v[m_owner];
            e_wdata = wdata_v[m_owner];
            e_wen   = we_v[m_owner];
            e_ren   = !we_v[m_owner];
        end
        check("gnt0",     32'(gnt0),     32'(m_owner == 0));
        check("gnt1",     32'(gnt1),     32'(m_owner == 1));
        check("onehot",   32'(gnt0 && gnt1), 32'(0));
        check("rvalid0",  32'(rvalid0),  32'(m_rvalid[0]));
        check("rvalid1",  32'(rvalid1),  32'(m_rvalid[1]));
        check("rdata0",   32'(rdata0),   32'(m_rdata[0]));
        check("rdata1",   32'(rdata1),   32'(m_rdata[1]));
        check("rf_ren",   32'(rf_ren),   32'(e_ren));
        check("rf_wen",   32'(rf_wen),   32'(e_wen));
        check("rf_raddr", 32'(rf_raddr), 32'(e_addr));
        check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        check("rf_wdata", 32'(rf_wdata), 32'(e_wdata));
    endtask

    task automatic tick();
        @(negedge Clk);
        if (chk_en) compare_model();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic poke(input int a, input logic [DW-1:0] d);
        poke_en    = 1'b1;
        poke_a     = AW'(a);
        poke_d     = d;
        ref_mem[a] = d;
        tick();
        poke_en    = 1'b0;
    endtask

    // Ticks until requester n holds the grant; an expired bound is a failure.
    task automatic wait_gnt(input int n, input int max_cyc, input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if ((n == 0 && gnt0) || (n == 1 && gnt1)) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'(1));
    endtask

    task automatic idle_inputs();
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
    endtask

    int            seq [48];
    int            run0, run1, pos, pulses;
    logic [DW-1:0] snap [16];

    initial begin
        rst     = 1'b1;
        poke_en = 1'b0;
        poke_a  = '0;
        poke_d  = '0;
        for (int n = 0; n < 2; n++) begin
            req_v[n] = 1'b0; we_v[n] = 1'b0; addr_v[n] = '0; wdata_v[n] = '0;
        end
        m_owner = -1; m_streak = 0; m_last = 1;
        m_rvalid[0] = 1'b0; m_rvalid[1] = 1'b0;
        m_rdata[0] = '0; m_rdata[1] = '0;

        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 5)      poke(i, 8'h37);
            else if (i == 7) poke(i, 8'h41);
            else             poke(i, 8'($urandom));
        end

        // Reset state
        check("rst_gnt0",    32'(gnt0),    32'(0));
        check("rst_gnt1",    32'(gnt1),    32'(0));
        check("rst_rvalid0", 32'(rvalid0), 32'(0));
        check("rst_rdata1",  32'(rdata1),  32'(0));
        check("rst_rf_ren",  32'(rf_ren),  32'(0));
        rst = 1'b0;
        tick();

        // Single read of entry 5
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'd5;
        #1;
        check("t1_gnt0_T", 32'(gnt0), 32'(0));
        tick();
        check("t1_gnt0_T1",  32'(gnt0),     32'(1));
        check("t1_ren_T1",   32'(rf_ren),   32'(1));
        check("t1_raddr_T1", 32'(rf_raddr), 32'(5));
        tick();
        check("t1_rvalid0_T2", 32'(rvalid0), 32'(1));
        check("t1_rdata0_T2",  32'(rdata0),  32'(8'h37));
        req_v[0] = 1'b0;
        #1;
        check("t1_gnt0_T2",  32'(gnt0),   32'(1));
        check("t1_ren_drop", 32'(rf_ren), 32'(0));
        tick();
        check("t1_gnt0_T3",    32'(gnt0),    32'(0));
        check("t1_rvalid0_T3", 32'(rvalid0), 32'(0));

        // Ties: from reset requester 0 wins, hand-over has no idle gap
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'd1;
        req_v[1] = 1'b1; we_v[1] = 1'b0; addr_v[1] = 4'd2;
        tick();
        check("t2_tie_gnt0", 32'(gnt0), 32'(1));
        check("t2_tie_gnt1", 32'(gnt1), 32'(0));
        req_v[0] = 1'b0;
        tick();
        check("t2_switch_gnt1", 32'(gnt1), 32'(1));
        check("t2_switch_gnt0", 32'(gnt0), 32'(0));
        req_v[1] = 1'b0;
        tick();
        tick();
        // requester 1 owned last: next tie goes to 0
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        tick();
        check("t2_tie2_gnt0", 32'(gnt0), 32'(1));
        idle_inputs();
        tick(); tick();
        // requester 0 owned last: next tie goes to 1
        req_v[0] = 1'b1; req_v[1] = 1'b1;
        tick();
        check("t2_tie3_gnt1", 32'(gnt1), 32'(1));
        idle_inputs();
        tick(); tick();

        // Bounded hold with both requesters writing
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 4'd10; wdata_v[0] = 8'hA0;
        tick();
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 4'd11; wdata_v[1] = 8'hB0;
        for (int k = 0; k < 48; k++) begin
            seq[k] = gnt0 ? 0 : (gnt1 ? 1 : -1);
            if (m_owner == 0) begin
                addr_v[0] = 4'($urandom_range(8, 15)); wdata_v[0] = 8'($urandom);
            end
            if (m_owner == 1) begin
                addr_v[1] = 4'($urandom_range(8, 15)); wdata_v[1] = 8'($urandom);
            end
            tick();
        end
        run0 = 0; pos = 0;
        while (pos < 48 && seq[pos] == 0) begin run0++; pos++; end
        run1 = 0;
        while (pos < 48 && seq[pos] == 1) begin run1++; pos++; end
        check("t3_run_gnt0", 32'(run0), 32'(16));
        check("t3_run_gnt1", 32'(run1), 32'(16));
        check("t3_back_to_0", 32'(pos < 48 ? seq[pos] : -1), 32'(0));
        idle_inputs();
        tick(); tick();

        // Write by 1, then read-back by 0
        req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 4'd3; wdata_v[1] = 8'h09;
        wait_gnt(1, 4, "t4_gnt1");
        tick();
        req_v[1] = 1'b0;
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'd3;
        wait_gnt(0, 4, "t4_gnt0");
        tick();
        req_v[0] = 1'b0;
        check("t4_rvalid0", 32'(rvalid0), 32'(1));
        check("t4_rdata0",  32'(rdata0),  32'(8'h09));
        tick();
        check("t4_rvalid0_once", 32'(rvalid0), 32'(0));
        tick();

        // Reset during a write access
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 4'd7; wdata_v[0] = 8'hAA;
        wait_gnt(0, 4, "t5_gnt0");
        rst = 1'b1;
        #1;
        check("t5_wen_in_rst", 32'(rf_wen), 32'(0));
        tick();
        check("t5_gnt0_after", 32'(gnt0),   32'(0));
        check("t5_mem7_kept",  32'(mem[7]), 32'(8'h41));
        rst = 1'b0;
        idle_inputs();
        tick();
        check("t5_no_rvalid", 32'(rvalid0), 32'(0));

        // Sequential read sweep 0..15
        for (int i = 0; i < 16; i++) snap[i] = mem[i];
        req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'd0;
        wait_gnt(0, 4, "t6_gnt0");
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (rvalid0) pulses++;
            check("t6_sweep_data", 32'(rdata0), 32'(snap[i-1]));
            if (i < 16) addr_v[0] = 4'(i);
            else        req_v[0] = 1'b0;
        end
        check("t6_pulses", 32'(pulses), 32'(16));
        tick();
        check("t6_rvalid_end", 32'(rvalid0), 32'(0));

        // Randomized traffic obeying the requester hold rule
        for (int k = 0; k < 500; k++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int n = 0; n < 2; n++) begin
                if (!(req_v[n] && m_owner != n)) begin
                    req_v[n]   = ($urandom_range(0, 99) < 65);
                    we_v[n]    = 1'($urandom_range(0, 1));
                    addr_v[n]  = 4'($urandom_range(0, 15));
                    wdata_v[n] = 8'($urandom);
                end
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick(); tick();
        for (int i = 0; i < 16; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
